// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter with its own bit timer
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8,
    parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          tx,
    output logic          busy,
    output logic          tx_done,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_push, w_pop, w_bit_end, w_not_empty;

    assign w_not_empty = (r_count != '0);
    assign w_bit_end   = (r_bit_cnt == BIT_LAST);
    assign w_push      = wr_valid && wr_ready;

    assign wr_ready   = (r_count != FULL);
    assign fifo_count = r_count;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || w_not_empty;
    assign tx_done    = (r_state == S_STOP) && w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Popping from IDLE or from the last stop cycle loads the next byte and drops tx together,
    // which is what keeps consecutive frames gap-free.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt      = 1'b1;
                w_bit_cnt_nxt = '0;
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_tx      <= w_tx_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo at CLKS_PER_BIT of 4, 16 and 1
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    int         sel = 0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v0, v1, v2;
    logic       r0, r1, r2, tx0, tx1, tx2, b0, b1, b2, d0, d1, d2;
    logic [3:0] c0, c1, c2;

    assign v0 = wr_valid && (sel == 0);
    assign v1 = wr_valid && (sel == 1);
    assign v2 = wr_valid && (sel == 2);

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut4 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(v0), .wr_ready(r0),
        .tx(tx0), .busy(b0), .tx_done(d0), .fifo_count(c0));
    uart_tx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut16 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(v1), .wr_ready(r1),
        .tx(tx1), .busy(b1), .tx_done(d1), .fifo_count(c1));
    uart_tx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(v2), .wr_ready(r2),
        .tx(tx2), .busy(b2), .tx_done(d2), .fifo_count(c2));

    logic       tx_m, busy_m, done_m, ready_m;
    logic [3:0] count_m;

    always_comb begin
        tx_m = tx0; busy_m = b0; done_m = d0; ready_m = r0; count_m = c0;
        if (sel == 1) begin
            tx_m = tx1; busy_m = b1; done_m = d1; ready_m = r1; count_m = c1;
        end else if (sel == 2) begin
            tx_m = tx2; busy_m = b2; done_m = d2; ready_m = r2; count_m = c2;
        end
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick;
        wr_valid = 1'b0;
    endtask

    function automatic int cpb_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 16 : 1;
    endfunction

    // Called on the first start-bit cycle; returns one cycle after the last stop cycle.
    task automatic check_frame(input string name, input logic [9:0] frame, input int cpb,
                               output int done_at);
        done_at = -1;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < cpb; c++) begin
                chk({name, "_tx"}, tx_m, frame[b]);
                chk({name, "_done"}, done_m, (b == 9 && c == cpb - 1) ? 1 : 0);
                chk({name, "_busy"}, busy_m, 1);
                if (done_m) done_at = cyc;
                tick;
            end
        end
    endtask

    logic [7:0] t4_data [12];
    int         da, db, acc, pushed, bad;
    logic       rdy_before;

    initial begin
        vecs[0] = '{0, 8'h55, 10'b1_0101_0101_0};
        vecs[1] = '{0, 8'h81, 10'b1_1000_0001_0};
        vecs[2] = '{2, 8'h3C, 10'b1_0011_1100_0};
        vecs[3] = '{1, 8'hA5, 10'b1_1010_0101_0};
        vecs[4] = '{2, 8'h00, 10'b1_0000_0000_0};
        for (int i = 0; i < 12; i++) t4_data[i] = 8'(8'h30 + i * 7);

        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_tx", tx_m, 1);
            chk("rst_done", done_m, 0);
            chk("rst_count", count_m, 0);
            chk("rst_busy", busy_m, 0);
            chk("rst_ready", ready_m, 1);
        end

        // single frames, table driven
        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].sel;
            write_byte(vecs[i].data);
            chk("vec_count_e0", count_m, 1);
            chk("vec_tx_e0", tx_m, 1);
            chk("vec_busy_e0", busy_m, 1);
            tick;
            chk("vec_count_e1", count_m, 0);
            check_frame("vec", vecs[i].frame, cpb_of(sel), da);
            chk("vec_busy_after", busy_m, 0);
            chk("vec_tx_after", tx_m, 1);
            chk("vec_done_after", done_m, 0);
        end

        // back-to-back at CLKS_PER_BIT=4
        sel = 0;
        write_byte(8'hA5);
        write_byte(8'h3C);
        chk("b2b_count", count_m, 1);
        check_frame("b2b_f0", 10'b1_1010_0101_0, 4, da);
        check_frame("b2b_f1", 10'b1_0011_1100_0, 4, db);
        chk("b2b_done_gap", db - da, 40);
        chk("b2b_idle_busy", busy_m, 0);

        // back-to-back at CLKS_PER_BIT=1
        sel = 2;
        write_byte(8'hFF);
        write_byte(8'h00);
        check_frame("cpb1_f0", 10'b1_1111_1111_0, 1, da);
        check_frame("cpb1_f1", 10'b1_0000_0000_0, 1, db);
        chk("cpb1_done_gap", db - da, 10);
        chk("cpb1_idle_busy", busy_m, 0);

        // fill and backpressure at CLKS_PER_BIT=16
        sel = 1;
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        tick;
        chk("fill_count_e0", count_m, 1);
        wr_data = 8'h01;
        tick;
        chk("fill_count_e1", count_m, 1);
        acc = 2;
        wr_data = 8'h02;
        fork
            begin
                for (int i = 0; i < 11; i++) check_frame("fill", {1'b1, 8'(i), 1'b0}, 16, da);
            end
            begin
                for (int k = 0; k < 2000 && acc < 11; k++) begin
                    rdy_before = ready_m;
                    tick;
                    if (rdy_before) begin
                        acc++;
                        if (acc == 9) begin
                            chk("fill_full_count", count_m, 8);
                            chk("fill_full_ready", ready_m, 0);
                        end
                        if (acc == 11) wr_valid = 1'b0;
                        else wr_data = 8'(acc);
                    end else if (ready_m) begin
                        chk("fill_reassert_count", count_m, 7);
                    end
                end
                chk("fill_accepted", acc, 11);
            end
        join
        wr_valid = 1'b0;
        chk("fill_idle_busy", busy_m, 0);

        // simultaneous push/pop at count 3, pointers wrap
        sel = 0;
        write_byte(t4_data[0]);
        wr_valid = 1'b1;
        wr_data  = t4_data[1];
        tick;
        pushed = 2;
        fork
            begin
                for (int i = 0; i < 12; i++) check_frame("wrap", {1'b1, t4_data[i], 1'b0}, 4, da);
            end
            begin
                wr_data = t4_data[2];
                tick;
                wr_data = t4_data[3];
                tick;
                wr_valid = 1'b0;
                chk("wrap_count3", count_m, 3);
                pushed = 4;
                for (int k = 0; k < 2000 && pushed < 12; k++) begin
                    if (done_m) begin
                        chk("wrap_cnt_before", count_m, 3);
                        wr_valid = 1'b1;
                        wr_data  = t4_data[pushed];
                        tick;
                        wr_valid = 1'b0;
                        chk("wrap_cnt_after", count_m, 3);
                        pushed++;
                    end else begin
                        tick;
                    end
                end
                chk("wrap_pushed", pushed, 12);
            end
        join
        chk("wrap_idle_busy", busy_m, 0);
        chk("wrap_idle_count", count_m, 0);

        // reset in the middle of data bit 3
        sel = 0;
        wr_valid = 1'b1;
        wr_data  = 8'h52;
        tick;
        wr_data = 8'h66;
        tick;
        wr_data = 8'h77;
        tick;
        wr_valid = 1'b0;
        chk("mid_count", count_m, 2);
        repeat (16) tick;
        chk("mid_tx_bit3", tx_m, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_tx", tx_m, 1);
        chk("mid_rst_count", count_m, 0);
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_done", done_m, 0);
        chk("mid_rst_ready", ready_m, 1);
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
        end
        chk("mid_quiet_bad_cycles", bad, 0);
        write_byte(8'hC3);
        tick;
        check_frame("mid_new", 10'b1_1100_0011_0, 4, da);
        chk("mid_new_busy", busy_m, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
